pc_sequencer: RTL and testbench

- Owns the program counter and sequences the PC+4 adder path: holds PC, requests each fetch, then selects the next PC from sequential, branch, jump or jump-register sources.
- Sits between instruction memory and the control/branch logic at the front of the MIPS datapath.
- Includes a fetch handshake, a stall hold, a misaligned-target error halt and a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 86 ++++++++
 tb/tb_pc_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer for the MIPS front end: fetch handshake, issue with
// stall hold, next-PC selection (jr > jump > branch > sequential), misaligned-jr halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               stall_i,
    input  logic               imem_ready_i,
    input  logic               branch_taken_i,
    input  logic [15:0]        branch_offset_i,
    input  logic               jump_i,
    input  logic [25:0]        jump_target_i,
    input  logic               jr_i,
    input  logic [31:0]        jr_addr_i,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc_plus4_o,
    output logic               imem_req_o,
    output logic               instr_valid_o,
    output logic [COUNT_W-1:0] retire_count_o,
    output logic               pc_error_o
);

    typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]        pc_plus4;
    logic [31:0]        br_disp;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_disp  = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
        pc_error_o    = 1'b0;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) state_d = ISSUE;
            end
            ISSUE: begin
                instr_valid_o = 1'b1;
                if (!stall_i) begin
                    // A misaligned jr halts with pc left on the jr itself and no retire.
                    if (jr_i && (jr_addr_i[1:0] != 2'b00)) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                        cnt_d   = cnt_q + 1'b1;
                        if (jr_i)              pc_d = jr_addr_i;
                        else if (jump_i)       pc_d = {pc_plus4[31:28], jump_target_i, 2'b00};
                        else if (branch_taken_i) pc_d = pc_plus4 + br_disp;
                        else                   pc_d = pc_plus4;
                    end
                end
            end
            HALT:    pc_error_o = 1'b1;
            default: state_d = BOOT;
        endcase
    end

    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4;
    assign retire_count_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch/jump/jr redirects,
// fetch wait and stall hold, PC wrap, async reset and misaligned-jr halt.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, branch_taken, jump, jr;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] jr_addr;
    logic [31:0] pc, pc_plus4, retire_count;
    logic        imem_req, instr_valid, pc_error;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
        .clk_i(clk), .reset_i(reset), .stall_i(stall), .imem_ready_i(imem_ready),
        .branch_taken_i(branch_taken), .branch_offset_i(branch_offset),
        .jump_i(jump), .jump_target_i(jump_target), .jr_i(jr), .jr_addr_i(jr_addr),
        .pc_o(pc), .pc_plus4_o(pc_plus4), .imem_req_o(imem_req),
        .instr_valid_o(instr_valid), .retire_count_o(retire_count), .pc_error_o(pc_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Check handshake outputs and pc together.
    task automatic chk_st(input string tag, input logic req, input logic vld, input logic [31:0] epc);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".vld"}, {31'd0, instr_valid}, {31'd0, vld});
        chk({tag, ".pc"}, pc, epc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; branch_taken = 1'b0;
        jump = 1'b0; jr = 1'b0; branch_offset = '0; jump_target = '0; jr_addr = '0;
        #12;
        chk_st("rst", 1'b0, 1'b0, 32'h0);
        chk("rst.cnt", retire_count, 32'd0);
        chk("rst.err", {31'd0, pc_error}, 32'd0);
        reset = 1'b0;

        // Sequential fetch with memory always ready
        tick(); chk_st("boot>fetch", 1'b1, 1'b0, 32'h0);
        tick(); chk_st("iss0", 1'b0, 1'b1, 32'h0);
        chk("pc_plus4", pc_plus4, 32'h4);
        tick(); chk_st("fetch4", 1'b1, 1'b0, 32'h4);
        tick(); chk_st("iss4", 1'b0, 1'b1, 32'h4);
        tick(); chk_st("fetch8", 1'b1, 1'b0, 32'h8);
        tick(); chk_st("iss8", 1'b0, 1'b1, 32'h8);
        tick(); chk_st("fetchC", 1'b1, 1'b0, 32'hC);
        chk("cnt3", retire_count, 32'd3);
        tick(); chk_st("issC", 1'b0, 1'b1, 32'hC);

        // Aligned jr to 0x100
        jr = 1'b1; jr_addr = 32'h100;
        tick(); jr = 1'b0;
        chk_st("jr100", 1'b1, 1'b0, 32'h100);
        chk("cnt4", retire_count, 32'd4);
        tick();

        // Backward branch of one word: 0x104 - 4
        branch_taken = 1'b1; branch_offset = 16'hFFFF;
        tick(); branch_taken = 1'b0;
        chk("br_neg", pc, 32'h100);
        tick();
        branch_taken = 1'b1; branch_offset = 16'h0003;
        tick(); branch_taken = 1'b0;
        chk("br_pos", pc, 32'h110);
        tick();

        // Jump beats branch; region bits from pc+4
        jr = 1'b1; jr_addr = 32'h4000_0010;
        tick(); jr = 1'b0;
        tick(); chk_st("iss4010", 1'b0, 1'b1, 32'h4000_0010);
        jump = 1'b1; jump_target = 26'h0000123; branch_taken = 1'b1; branch_offset = 16'h0040;
        tick(); jump = 1'b0; branch_taken = 1'b0;
        chk("jmp_over_br", pc, 32'h4000_048C);
        chk("cnt8", retire_count, 32'd8);
        tick();

        // Fetch wait then stall hold with a jump pulse that must be ignored
        imem_ready = 1'b0;
        tick(); chk_st("wait0", 1'b1, 1'b0, 32'h4000_0490);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_st("wait", 1'b1, 1'b0, 32'h4000_0490);
        end
        imem_ready = 1'b1; stall = 1'b1;
        tick(); chk_st("stall_iss", 1'b0, 1'b1, 32'h4000_0490);
        for (int i = 0; i < 3; i++) begin
            jump = (i == 1); jump_target = 26'h3FFFFFF;
            tick(); chk_st("stall", 1'b0, 1'b1, 32'h4000_0490);
            chk("stall.cnt", retire_count, 32'd9);
        end
        stall = 1'b0; jump = 1'b0;
        tick(); chk_st("unstall", 1'b1, 1'b0, 32'h4000_0494);
        chk("cnt10", retire_count, 32'd10);

        // Sequential wrap from the top of the address space
        tick();
        jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
        tick(); jr = 1'b0;
        chk("pc_top", pc, 32'hFFFF_FFFC);
        tick();
        tick(); chk_st("wrap", 1'b1, 1'b0, 32'h0);
        chk("cnt12", retire_count, 32'd12);
        tick(); tick();
        chk_st("fetch4b", 1'b1, 1'b0, 32'h4);

        // Asynchronous reset between edges while fetching
        #3; reset = 1'b1; #1;
        chk_st("async_rst", 1'b0, 1'b0, 32'h0);
        chk("async_rst.cnt", retire_count, 32'd0);
        #1; reset = 1'b0;

        // Misaligned jr (with jump also asserted) halts
        tick(); tick(); chk_st("iss0b", 1'b0, 1'b1, 32'h0);
        jr = 1'b1; jr_addr = 32'h0000_0402; jump = 1'b1;
        tick(); jr = 1'b0; jump = 1'b0;
        chk_st("halt", 1'b0, 1'b0, 32'h0);
        chk("halt.err", {31'd0, pc_error}, 32'd1);
        chk("halt.cnt", retire_count, 32'd0);
        tick(); tick();
        chk_st("halt_hold", 1'b0, 1'b0, 32'h0);
        chk("halt_hold.err", {31'd0, pc_error}, 32'd1);
        #2; reset = 1'b1; #1;
        chk("halt_rst.err", {31'd0, pc_error}, 32'd0);
        chk("halt_rst.pc", pc, 32'h0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
